// File: rtl/uart_hex_tx_formatter.sv
// Binary-to-ASCII hex formatter feeding a UART Tx FIFO.
// Prints a DATA_W-bit word MSB nibble first in uppercase hex, optionally
// followed by CR LF. Each character is offered until the FIFO accepts it.
//
// state | meaning
// IDLE  | waiting for start; captures value and digit count on start
// HEX   | presenting top nibble of shift register as an ASCII hex digit
// CR    | presenting carriage return (0x0D)
// LF    | presenting line feed (0x0A)
// DONE  | one-cycle completion pulse, start ignored, returns to IDLE
module uart_hex_tx_formatter #(
    parameter int DATA_W      = 32,
    parameter int APPEND_CRLF = 1,
    parameter int DBITS       = 8
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              tx_full,
    output logic              busy,
    output logic              write_uart,
    output logic [DBITS-1:0]  write_data,
    output logic              done
);

    localparam int NDIG = DATA_W / 4;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEX  = 3'd1,
        CR   = 3'd2,
        LF   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [3:0]        nib;
    logic [7:0]        hex_char;
    logic [7:0]        char_sel;

    assign nib = shreg[DATA_W-1 -: 4];

    // Nibble to uppercase ASCII: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    always_comb begin
        hex_char = 8'h30 + {4'h0, nib};
        if (nib > 4'd9) begin
            hex_char = 8'h37 + {4'h0, nib};
        end
    end

    // Outputs decoded from registered state; a write happens only when the FIFO has room
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        char_sel   = 8'h00;
        case (state)
            HEX: begin
                busy     = 1'b1;
                char_sel = hex_char;
            end
            CR: begin
                busy     = 1'b1;
                char_sel = 8'h0D;
            end
            LF: begin
                busy     = 1'b1;
                char_sel = 8'h0A;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        write_uart = busy & ~tx_full;
        write_data = DBITS'(char_sel);
    end

    // Next-state logic; every advance is gated by an accepted write
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt = value;
                    cnt_nxt   = CW'(NDIG);
                    state_nxt = HEX;
                end
            end
            HEX: begin
                if (write_uart) begin
                    shreg_nxt = shreg << 4;
                    cnt_nxt   = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = (APPEND_CRLF != 0) ? CR : DONE;
                    end
                end
            end
            CR: begin
                if (write_uart) begin
                    state_nxt = LF;
                end
            end
            LF: begin
                if (write_uart) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, shift register and digit down-counter
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_hex_tx_formatter.sv
// Scoreboard bench for uart_hex_tx_formatter: a 32-bit CRLF instance and an
// 8-bit digits-only instance. Stimulus pushes hand-computed characters and a
// done token; monitors pop and compare whenever the DUTs write or finish.
module tb_uart_hex_tx_formatter;

    localparam logic [8:0] TOK_DONE = 9'h100;

    logic        clk_100MHz = 1'b0;
    logic        reset;

    logic        start_a, tx_full_a;
    logic [31:0] value_a;
    logic        busy_a, write_uart_a, done_a;
    logic [7:0]  write_data_a;

    logic        start_b, tx_full_b;
    logic [7:0]  value_b;
    logic        busy_b, write_uart_b, done_b;
    logic [7:0]  write_data_b;

    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    logic        prev_wr_a = 1'b0;
    logic        prev_wr_b = 1'b0;
    logic [8:0]  ea, eb;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_hex_tx_formatter #(.DATA_W(32), .APPEND_CRLF(1), .DBITS(8)) dut_a (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .start      (start_a),
        .value      (value_a),
        .tx_full    (tx_full_a),
        .busy       (busy_a),
        .write_uart (write_uart_a),
        .write_data (write_data_a),
        .done       (done_a)
    );

    uart_hex_tx_formatter #(.DATA_W(8), .APPEND_CRLF(0), .DBITS(8)) dut_b (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .start      (start_b),
        .value      (value_b),
        .tx_full    (tx_full_b),
        .busy       (busy_b),
        .write_uart (write_uart_b),
        .write_data (write_data_b),
        .done       (done_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor A: pop and compare on every write and every done pulse
    always @(negedge clk_100MHz) begin
        if (write_uart_a) begin
            check("a_busy_on_write", busy_a, 1'b1);
            if (qa.size() == 0) begin
                check("a_unexpected_write", {1'b0, write_data_a}, 9'h1FF);
            end else begin
                ea = qa.pop_front();
                check("a_char", {1'b0, write_data_a}, ea);
            end
        end else if (done_a) begin
            check("a_done_after_write", prev_wr_a, 1'b1);
            check("a_busy_in_done", busy_a, 1'b0);
            if (qa.size() == 0) begin
                check("a_unexpected_done", 1'b1, 1'b0);
            end else begin
                ea = qa.pop_front();
                check("a_done_token", ea, TOK_DONE);
            end
        end else if (busy_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_busy", busy_a, 1'b0);
            end else begin
                check("a_stall_hold", {1'b0, write_data_a}, qa[0]);
            end
        end else begin
            check("a_idle_data", write_data_a, 8'h00);
        end
        prev_wr_a = write_uart_a;
    end

    // Monitor B: same scoreboard for the 8-bit digits-only instance
    always @(negedge clk_100MHz) begin
        if (write_uart_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_write", {1'b0, write_data_b}, 9'h1FF);
            end else begin
                eb = qb.pop_front();
                check("b_char", {1'b0, write_data_b}, eb);
            end
        end else if (done_b) begin
            check("b_done_after_write", prev_wr_b, 1'b1);
            if (qb.size() == 0) begin
                check("b_unexpected_done", 1'b1, 1'b0);
            end else begin
                eb = qb.pop_front();
                check("b_done_token", eb, TOK_DONE);
            end
        end else if (!busy_b) begin
            check("b_idle_data", write_data_b, 8'h00);
        end
        prev_wr_b = write_uart_b;
    end

    // One message on DUT A; masks are indexed by cycle after start acceptance
    task automatic send_a(input logic [31:0] v, input string hex,
                          input logic [31:0] full_mask, input logic [31:0] ign_mask,
                          input int exp_done);
        int got;
        for (int i = 0; i < hex.len(); i++) qa.push_back({1'b0, hex[i]});
        qa.push_back(9'h00D);
        qa.push_back(9'h00A);
        qa.push_back(TOK_DONE);
        @(posedge clk_100MHz); #1;
        start_a   = 1'b1;
        value_a   = v;
        tx_full_a = 1'b0;
        got = -1;
        for (int c = 1; c < 32 && got < 0; c++) begin
            @(posedge clk_100MHz); #1;
            start_a   = ign_mask[c];
            value_a   = ign_mask[c] ? 32'h11111111 : 32'h5A5A5A5A;
            tx_full_a = full_mask[c];
            @(negedge clk_100MHz);
            check("a_busy_window", busy_a, (c < exp_done));
            if (done_a) got = c;
        end
        start_a   = 1'b0;
        tx_full_a = 1'b0;
        check("a_done_cycle", got, exp_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        reset = 1'b0;
        start_a = 1'b0; tx_full_a = 1'b0; value_a = '0;
        start_b = 1'b0; tx_full_b = 1'b0; value_b = '0;
        #3;
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_write_a", write_uart_a, 1'b0);
        check("rst_data_a", write_data_a, 8'h00);
        check("rst_done_a", done_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        #9 reset = 1'b1;
        repeat (2) @(posedge clk_100MHz);

        // Basic print, then digit boundaries back-to-back from cycle N+2
        send_a(32'hDEADBEEF, "DEADBEEF", 32'h0, 32'h0, 11);
        send_a(32'h0123A9F0, "0123A9F0", 32'h0, 32'h0, 11);

        // Back-pressure on cycles 3-5 and on the LF cycle (13)
        send_a(32'h000000FF, "000000FF", 32'h0000_2038, 32'h0, 15);

        // Starts at cycle 4 and in the DONE cycle are ignored; next start at N+2
        send_a(32'hDEADBEEF, "DEADBEEF", 32'h0, 32'h0000_0810, 11);
        send_a(32'h11111111, "11111111", 32'h0, 32'h0, 11);

        // Reset asynchronously after three characters have been written
        qa.push_back({1'b0, 8'h44});
        qa.push_back({1'b0, 8'h45});
        qa.push_back({1'b0, 8'h41});
        @(posedge clk_100MHz); #1;
        start_a = 1'b1;
        value_a = 32'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk_100MHz); #1;
            start_a = 1'b0;
        end
        @(posedge clk_100MHz); #2;
        check("mid_busy_before_rst", busy_a, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_write", write_uart_a, 1'b0);
        check("rst_mid_done", done_a, 1'b0);
        check("rst_mid_chars_seen", qa.size(), 0);
        repeat (2) @(posedge clk_100MHz);
        #3 reset = 1'b1;
        repeat (5) @(posedge clk_100MHz);
        send_a(32'h0000ABCD, "0000ABCD", 32'h0, 32'h0, 11);

        // Digits-only 8-bit instance: 0x7E -> '7' 'E', done on cycle 3
        qb.push_back({1'b0, 8'h37});
        qb.push_back({1'b0, 8'h45});
        qb.push_back(TOK_DONE);
        @(posedge clk_100MHz); #1;
        start_b = 1'b1;
        value_b = 8'h7E;
        got = -1;
        for (int c = 1; c < 10 && got < 0; c++) begin
            @(posedge clk_100MHz); #1;
            start_b = 1'b0;
            value_b = 8'h00;
            @(negedge clk_100MHz);
            check("b_busy_window", busy_b, (c < 3));
            if (done_b) got = c;
        end
        check("b_done_cycle", got, 3);

        repeat (6) @(posedge clk_100MHz);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
